// File: rtl/line_refill_responder.sv
// Cache line refill responder: accepts a line request, then streams the line
// out of a local word store one bus beat at a time (FETCH, then RESP per beat).
module line_refill_responder #(
  parameter int MAX_MEM      = 16,
  parameter int BUS_BYTESE   = 2,
  parameter int CACHE_WIDTHE = 4,
  parameter int MEM_DEPTHE   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [MAX_MEM-1:0]           req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [(8<<BUS_BYTESE)-1:0]   rsp_data,
  output logic                         rsp_last,
  output logic                         rsp_err,
  input  logic                         wr_en,
  input  logic [MEM_DEPTHE-1:0]        wr_idx,
  input  logic [(8<<BUS_BYTESE)-1:0]   wr_data
);

  localparam int DW    = 8 << BUS_BYTESE;
  localparam int LW    = CACHE_WIDTHE - BUS_BYTESE;
  localparam int BEATS = 1 << LW;
  localparam int BW    = (LW > 1) ? LW : 1;
  localparam int AW    = MEM_DEPTHE + BUS_BYTESE;
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
  localparam logic [MEM_DEPTHE-1:0] OFF_MASK  = MEM_DEPTHE'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [MEM_DEPTHE-1:0]  base_q, base_d;
  logic                   err_q, err_d;
  logic [DW-1:0]          data_q, data_d;
  logic [MEM_DEPTHE-1:0]  rd_idx;
  logic [DW-1:0]          mem [0:(1<<MEM_DEPTHE)-1];

  // The base has its in-line offset bits cleared, so OR-ing the beat in can
  // never carry into the line base.
  assign rd_idx = base_q | MEM_DEPTHE'(beat_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_addr[AW-1:BUS_BYTESE] & ~OFF_MASK;
          beat_d  = '0;
          err_d   = |(req_addr >> AW);
          state_d = FETCH;
        end
      end
      FETCH: begin
        data_d  = mem[rd_idx];
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Store contents survive reset; a same-edge write is not seen by the FETCH read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_last  = rsp_valid && (beat_q == LAST_BEAT);
    rsp_err   = rsp_valid && err_q;
    rsp_data  = (rsp_valid && !err_q) ? data_q : '0;
  end

endmodule

// File: tb/tb_line_refill_responder.sv
// Bench for line_refill_responder: a transaction-level model checked every
// cycle, plus directed scenarios with literal expected beats.
module tb_line_refill_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        wr_en;
  logic [7:0]  wr_idx;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic [33:0] got_q[$];

  line_refill_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a line of 4 words; each beat's word is read from the store one
  // cycle after the previous beat left (or the request was taken), then
  // offered until accepted.
  logic [31:0] m_mem [0:255];
  logic        m_busy  = 1'b0;
  logic        m_fetch = 1'b0;
  int          m_beat  = 0;
  logic [7:0]  m_base  = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_data  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy  = 1'b1;
          m_fetch = 1'b1;
          m_beat  = 0;
          m_base  = 8'(req_addr >> 2) & 8'hFC;
          m_err   = (req_addr >> 10) != 0;
        end
      end else if (m_fetch) begin
        m_data  = m_err ? 32'h0 : m_mem[8'(m_base + m_beat)];
        m_fetch = 1'b0;
      end else if (rsp_ready) begin
        if (m_beat == 3) m_busy = 1'b0;
        else begin
          m_beat  = m_beat + 1;
          m_fetch = 1'b1;
        end
      end
      if (wr_en) m_mem[wr_idx] = wr_data;
    end
  end

  always @(negedge clk) begin
    logic e_valid;
    e_valid = m_busy && !m_fetch;
    check("req_ready", req_ready, !m_busy);
    check("rsp_valid", rsp_valid, e_valid);
    check("rsp_last",  rsp_last,  e_valid && m_beat == 3);
    check("rsp_err",   rsp_err,   e_valid && m_err);
    check("rsp_data",  rsp_data,  e_valid ? m_data : 32'h0);
    if (rst_n && rsp_valid && rsp_ready) got_q.push_back({rsp_last, rsp_err, rsp_data});
    if (rst_n && req_valid && req_ready) n_acc++;
  end

  task automatic write_word(input logic [7:0] idx, input logic [31:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic request(input logic [15:0] addr);
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
    end while (got_q.size() < n && cyc < 300);
    check("beat_count", got_q.size(), n);
    #1;
  endtask

  task automatic check_line(input string tag, input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3, input logic err);
    logic [31:0] exp_d [4];
    exp_d[0] = b0; exp_d[1] = b1; exp_d[2] = b2; exp_d[3] = b3;
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check({tag, "_data"}, got_q[i][31:0], exp_d[i]);
        check({tag, "_last"}, got_q[i][33], (i == 3));
        check({tag, "_err"},  got_q[i][32], err);
      end else begin
        check({tag, "_missing"}, got_q.size(), 4);
      end
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data",  rsp_data,  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      write_word(8'(i), (i >= 4 && i < 8) ? 32'hA0 + 32'(i - 4) : 32'h100 + 32'(i));

    // Basic burst and first-beat latency
    got_q.delete();
    request(16'h0013);
    @(negedge clk);
    check("lat_fetch_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("lat_first_valid", rsp_valid, 1'b1);
    check("lat_first_data",  rsp_data,  32'hA0);
    wait_beats(4);
    check_line("basic", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);

    // Stall on beat 1 for five cycles
    got_q.delete();
    request(16'h0013);
    wait_beats(1);
    rsp_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data",  rsp_data,  32'hA1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_data", rsp_data, 32'hA1);
    @(negedge clk);
    check("release_gap", rsp_valid, 1'b0);
    @(negedge clk);
    check("release_next_valid", rsp_valid, 1'b1);
    check("release_next_data",  rsp_data,  32'hA2);
    wait_beats(4);
    check_line("stall", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);

    // Out-of-range address
    got_q.delete();
    request(16'h0400);
    wait_beats(4);
    check_line("err", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("err_back_idle", req_ready, 1'b1);
    @(posedge clk); #1;

    // Write to the word being fetched for beat 2
    got_q.delete();
    request(16'h0013);
    wait_beats(2);
    write_word(8'd6, 32'h55);
    wait_beats(4);
    check_line("collide", 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);
    got_q.delete();
    request(16'h0010);
    wait_beats(4);
    check_line("after_wr", 32'hA0, 32'hA1, 32'h55, 32'hA3, 1'b0);

    // Reset during beat 1
    got_q.delete();
    request(16'h0013);
    wait_beats(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_data",  rsp_data,  32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_more_beats", got_q.size(), 1);
    got_q.delete();
    request(16'h0013);
    wait_beats(4);
    check_line("post_rst", 32'hA0, 32'hA1, 32'h55, 32'hA3, 1'b0);

    // req_valid held high: one burst per IDLE visit
    got_q.delete();
    n_acc = 0;
    req_valid = 1'b1; req_addr = 16'h0013;
    wait_beats(4);
    check("held_acc_mid", n_acc, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_beats(8);
    repeat (4) @(posedge clk);
    #1;
    check("held_acc_total", n_acc, 2);
    check("held_beats", got_q.size(), 8);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
